// File: rtl/mf_cen_pkg.sv
// Shared types for the multi-channel fractional clock-enable generator.
// Config fields are stored at CEN_ACC_W_MAX bits; channels use the low ACC_W bits.
package mf_cen_pkg;

    localparam int unsigned CEN_ACC_W     = 24;
    localparam int unsigned CEN_ACC_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        SETTLE,
        LOCKED
    } cen_state_e;

    typedef struct packed {
        logic [CEN_ACC_W_MAX-1:0] num;
        logic [CEN_ACC_W_MAX-1:0] den;
        logic [CEN_ACC_W_MAX-1:0] phase;
    } chan_cfg_t;

endpackage

// File: rtl/mf_cen_chan.sv
// One num/den phase accumulator producing a registered enable pulse.
// The divided square output is built only when MF_CEN_CLKDIV_EN is defined.
module mf_cen_chan
    import mf_cen_pkg::*;
#(
    parameter int unsigned ACC_W = CEN_ACC_W
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      step_i,
    input  logic      clr_i,
    input  chan_cfg_t cfg_i,
    output logic      cen_o,
    output logic      clk_div_o
);

    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             cen_q, cen_d;
    logic [ACC_W-1:0] ld_den, ld_phase, phase_red, num_eff;
    logic [ACC_W:0]   sum;
    logic             hit;

    always_comb begin
        ld_den   = ACC_W'(cfg_i.den);
        ld_phase = ACC_W'(cfg_i.phase);
        // A single subtract reduces the phase; anything still too large is clamped.
        if (ld_den == '0)
            phase_red = '0;
        else if (ld_phase < ld_den)
            phase_red = ld_phase;
        else if ((ld_phase - ld_den) < ld_den)
            phase_red = ld_phase - ld_den;
        else
            phase_red = ld_den - ACC_W'(1);

        num_eff = (num_q >= den_q) ? den_q : num_q;
        sum     = {1'b0, acc_q} + {1'b0, num_eff};
        hit     = (den_q != '0) && (sum >= {1'b0, den_q});

        num_d = num_q;
        den_d = den_q;
        acc_d = acc_q;
        cen_d = 1'b0;
        if (load_i) begin
            num_d = ACC_W'(cfg_i.num);
            den_d = ld_den;
            acc_d = phase_red;
        end else if (step_i && !clr_i) begin
            cen_d = hit;
            if (hit)
                acc_d = ACC_W'(sum - {1'b0, den_q});
            else if (den_q != '0)
                acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= '0;
            den_q <= '0;
            acc_q <= '0;
            cen_q <= 1'b0;
        end else begin
            num_q <= num_d;
            den_q <= den_d;
            acc_q <= acc_d;
            cen_q <= cen_d;
        end
    end

    assign cen_o = cen_q;

`ifdef MF_CEN_CLKDIV_EN
    logic div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (load_i || clr_i)
            div_d = 1'b0;
        else if (step_i && hit)
            div_d = ~div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_q <= 1'b0;
        else
            div_q <= div_d;
    end

    assign clk_div_o = div_q;
`else
    assign clk_div_o = 1'b0;
`endif

endmodule

// File: rtl/mf_cen_multi.sv
// Multi-channel fractional clock-enable generator with PLL-style lock indication.
// Define MF_CEN_CLKDIV_EN to build the per-channel divided square outputs.
module mf_cen_multi
    import mf_cen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned ACC_W       = CEN_ACC_W,
    parameter int unsigned LOCK_CYCLES = 1024,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] cen,
    output logic [NUM_CH-1:0] clk_div,
    output logic              locked
);

    localparam int unsigned LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    cen_state_e       state_q, state_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    chan_cfg_t        shadow_q [NUM_CH];
    chan_cfg_t        cfg_wr;
    logic             cfg_hit;
    logic             ch_load, ch_step, ch_clr;

    always_comb begin
        cfg_hit      = cfg_we && (32'(cfg_ch) < NUM_CH);
        cfg_wr.num   = CEN_ACC_W_MAX'(cfg_num);
        cfg_wr.den   = CEN_ACC_W_MAX'(cfg_den);
        cfg_wr.phase = CEN_ACC_W_MAX'(cfg_phase);

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (run)
                    state_d = ALIGN;
            end
            ALIGN: begin
                lock_cnt_d = '0;
                state_d    = cfg_hit ? ALIGN : SETTLE;
            end
            SETTLE: begin
                if (cfg_hit) begin
                    state_d    = ALIGN;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end
            end
            LOCKED: begin
                if (cfg_hit) begin
                    state_d    = ALIGN;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!run) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end

        // A write during SETTLE/LOCKED suppresses the step so cen is already low in ALIGN.
        ch_load = (state_q == ALIGN);
        ch_step = ((state_q == SETTLE) || (state_q == LOCKED)) && !cfg_hit;
        ch_clr  = !run || (state_q == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                shadow_q[i] <= '0;
        end else if (cfg_hit) begin
            for (int unsigned i = 0; i < NUM_CH; i++)
                if (cfg_ch == CH_W'(i))
                    shadow_q[i] <= cfg_wr;
        end
    end

    assign locked = (state_q == LOCKED);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mf_cen_chan #(
            .ACC_W(ACC_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (reset_n),
            .load_i   (ch_load),
            .step_i   (ch_step),
            .clr_i    (ch_clr),
            .cfg_i    (shadow_q[g]),
            .cen_o    (cen[g]),
            .clk_div_o(clk_div[g])
        );
    end

endmodule

// File: tb/tb_mf_cen_multi.sv
// Scoreboard bench for mf_cen_multi: stimulus queues per-cycle expectations,
// a monitor pops and compares them after each clock edge or reset assertion.
module tb_mf_cen_multi;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [23:0] cfg_num, cfg_den, cfg_phase;
    logic [4:0]  cen, clk_div;
    logic        locked;

    typedef struct {
        logic [4:0] cen;
        logic       locked;
        logic [4:0] div;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] div_model;
    int         checks;
    int         failures;

    mf_cen_multi #(
        .NUM_CH     (5),
        .ACC_W      (24),
        .LOCK_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .cfg_phase(cfg_phase),
        .cen      (cen),
        .clk_div  (clk_div),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string tag, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @%s got=%b want=%b", nm, tag, got, want);
        end
    endtask

    task automatic push(input logic [4:0] c, input logic l, input string tag);
        exp_t e;
        e.cen    = c;
        e.locked = l;
`ifdef MF_CEN_CLKDIV_EN
        e.div    = div_model;
`else
        e.div    = 5'b0;
`endif
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    // Hand-derived pulse positions after the k-th SETTLE step:
    // ch0 1/4 -> k%4==0 (1/2 after reconfig -> k%2==0); ch1 3/8 -> k%8 in {3,6,0}
    // (1/3 after reconfig -> k%3==0); ch2 1/4 phase 3 -> k%4==1; ch3 den=0 -> never;
    // ch4 5/3 -> always.
    function automatic logic [4:0] pat(input int k, input bit fast);
        logic [4:0] p;
        p    = 5'b0;
        p[0] = fast ? (k % 2 == 0) : (k % 4 == 0);
        p[1] = fast ? (k % 3 == 0) : ((k % 8 == 0) || (k % 8 == 3) || (k % 8 == 6));
        p[2] = (k % 4 == 1);
        p[3] = 1'b0;
        p[4] = 1'b1;
        return p;
    endfunction

    task automatic step(input int k, input bit fast);
        logic [4:0] c;
        c         = pat(k, fast);
        div_model = div_model ^ c;
        push(c, (k >= 16), $sformatf("s%0d", k));
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int n, input int d, input int p);
        cfg_we    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_num   = 24'(n);
        cfg_den   = 24'(d);
        cfg_phase = 24'(p);
        push(5'b0, 1'b0, $sformatf("idle_wr%0d", ch));
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cen", e.tag, cen, e.cen);
                chk("locked", e.tag, {4'b0, locked}, {4'b0, e.locked});
                chk("clk_div", e.tag, clk_div, e.div);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        checks    = 0;
        failures  = 0;
        div_model = 5'b0;
        reset_n   = 1'b0;
        run       = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = 3'd0;
        cfg_num   = '0;
        cfg_den   = '0;
        cfg_phase = '0;

        @(negedge clk);
        push(5'b0, 1'b0, "rst");
        @(negedge clk);
        reset_n = 1'b1;

        wr(0, 1, 4, 0);
        wr(1, 3, 8, 0);
        wr(2, 1, 4, 3);
        wr(3, 1, 0, 7);
        wr(4, 5, 3, 0);

        run = 1'b1;
        push(5'b0, 1'b0, "align");
        @(negedge clk);
        push(5'b0, 1'b0, "settle0");
        @(negedge clk);
        for (int k = 1; k <= 24; k++) begin
            if (k == 21) begin
                cfg_we  = 1'b1;
                cfg_ch  = 3'd5;
                cfg_num = 24'd1;
                cfg_den = 24'd2;
            end
            step(k, 1'b0);
            cfg_we = 1'b0;
        end

        // Reconfigure while locked, then write again during ALIGN
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_num = 24'd1; cfg_den = 24'd2; cfg_phase = 24'd0;
        push(5'b0, 1'b0, "reconf_align");
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_num = 24'd1; cfg_den = 24'd3; cfg_phase = 24'd0;
        div_model = 5'b0;
        push(5'b0, 1'b0, "align2");
        @(negedge clk);
        cfg_we = 1'b0;
        push(5'b0, 1'b0, "settle0b");
        @(negedge clk);
        for (int k = 1; k <= 18; k++)
            step(k, 1'b1);

        run       = 1'b0;
        div_model = 5'b0;
        push(5'b0, 1'b0, "stop");
        @(negedge clk);
        push(5'b0, 1'b0, "idle");
        @(negedge clk);

        // Restart, then assert reset mid-cycle while channels are active
        run = 1'b1;
        push(5'b0, 1'b0, "align3");
        @(negedge clk);
        push(5'b0, 1'b0, "settle0c");
        @(negedge clk);
        for (int k = 1; k <= 5; k++)
            step(k, 1'b1);
        div_model = 5'b0;
        push(5'b0, 1'b0, "async_rst");
        #2;
        reset_n = 1'b0;
        push(5'b0, 1'b0, "in_rst");
        @(negedge clk);
        reset_n = 1'b1;
        push(5'b0, 1'b0, "align_after_rst");
        @(negedge clk);
        push(5'b0, 1'b0, "settle0d");
        @(negedge clk);
        // Shadows were cleared by reset: all channels disabled, lock still arrives at step 16
        for (int k = 1; k <= 17; k++) begin
            push(5'b0, (k >= 16), $sformatf("r%0d", k));
            @(negedge clk);
        end

        run = 1'b0;
        push(5'b0, 1'b0, "stop2");
        @(negedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
